fifo_wr_arbiter: RTL

Round-robin write-side arbiter that shares one FIFO write port among NUM_REQ requesters. It grants one requester at a time for a burst of up to BURST_LEN words and registers the winning data onto the FIFO write interface. It throttles on the FIFO's almost-full flag. It sits in the FIFO write-clock domain, directly ahead of the async/sync FIFO write port.

---
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, bursts of up to BURST_LEN words.
// Latency: accepted word appears on o_wr/o_wdata 1 cycle after its o_gnt strobe; each grant costs 1 arbitration cycle.
// Backpressure: i_walmostfull/i_wfull stall the owner in place; FIFO_WR_ARB_STATS_EN adds stall/burst-done stats.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  input  logic                          i_walmostfull,
  input  logic                          i_wfull,
  output logic                          o_wr,
  output logic [DATA_WIDTH-1:0]         o_wdata,
  output logic [$clog2(NUM_REQ)-1:0]    o_owner,
  output logic                          o_busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                   o_stall_cnt,
  output logic                          o_burst_done
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_inc;
  logic [CNT_W-1:0] burst_cnt;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             pick_vld;
  logic             req_own;
  logic             accept;
  logic             last_word;
  logic             grant_exit;

  // Walk offsets from the far end so the lowest offset from rr_ptr wins.
  // Modulo (not truncation) keeps non-power-of-2 NUM_REQ in range.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (i_req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  assign owner_inc  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign req_own    = i_req[owner];
  assign accept     = (state == GRANT) & req_own & ~i_walmostfull & ~i_wfull & ~i_rst;
  assign last_word  = accept & (burst_cnt == CNT_W'(BURST_LEN - 1));
  assign grant_exit = (state == GRANT) & (last_word | ~req_own);

  always_comb begin
    o_gnt        = '0;
    o_gnt[owner] = accept;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      o_wr      <= 1'b0;
      o_wdata   <= '0;
    end else begin
      o_wr <= accept;
      if (accept) begin
        o_wdata   <= i_data[owner*DATA_WIDTH +: DATA_WIDTH];
        burst_cnt <= burst_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner     <= pick_idx;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        default: begin
          if (grant_exit) begin
            state  <= IDLE;
            rr_ptr <= owner_inc;
          end
        end
      endcase
    end
  end

  assign o_owner = owner;
  assign o_busy  = (state == GRANT);

`ifdef FIFO_WR_ARB_STATS_EN
  logic stall;

  assign stall = (state == GRANT) & req_own & ~accept;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt  <= '0;
      o_burst_done <= 1'b0;
    end else begin
      if (stall && (o_stall_cnt != 16'hFFFF))
        o_stall_cnt <= o_stall_cnt + 16'd1;
      o_burst_done <= grant_exit;
    end
  end
`endif

endmodule
